// File: rtl/audio_sample_scheduler_if.sv
// Upstream valid/ready channel carrying one signed L/R sample pair per transfer.
interface audio_sample_scheduler_if #(
  parameter int unsigned WIDTH = 18
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_left;
  logic signed [WIDTH-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/audio_sample_scheduler.sv
// Stereo sample scheduler: FIFO-buffers L/R pairs and releases one pair per 48 kHz tick,
// with prefill, underrun hold, mute-after-starvation and synchronous flush.
module audio_sample_scheduler #(
  parameter int unsigned WIDTH      = 18,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PREFILL    = 4,
  parameter int unsigned MUTE_AFTER = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clken48kHz,
  input  logic                       flush,
  audio_sample_scheduler_if.slave    in_if,
  output logic signed [WIDTH-1:0]    LEFTout,
  output logic signed [WIDTH-1:0]    RIGHTout,
  output logic                       sample_upd,
  output logic                       running,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [7:0]                 underflow_cnt
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned TickW = $clog2(MUTE_AFTER + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StUnder = 2'd2;

  logic [2*WIDTH-1:0]    mem_q [DEPTH];
  logic [2*WIDTH-1:0]    mem_d [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic signed [WIDTH-1:0] left_q, left_d;
  logic signed [WIDTH-1:0] right_q, right_d;
  logic                  upd_q, upd_d;
  logic [7:0]            uf_q, uf_d;
  logic [TickW-1:0]      ticks_q, ticks_d;
  logic [TickW-1:0]      ticks_nxt;

  logic                  full, empty, push, pop;
  logic [2*WIDTH-1:0]    head;

  assign full            = (count_q == CntW'(DEPTH));
  assign empty           = (count_q == '0);
  assign in_if.in_ready  = !full && !flush;
  assign push            = in_if.in_valid && in_if.in_ready;
  // Emptiness comes from the registered count, so a same-edge push never feeds a pop.
  assign pop             = clken48kHz && !empty && (state_q != StIdle) && !flush;
  assign head            = mem_q[rd_ptr_q];

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_if.in_left, in_if.in_right};
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PtrW'(push);
    rd_ptr_d  = rd_ptr_q + PtrW'(pop);
    count_d   = count_q + CntW'(push) - CntW'(pop);
    state_d   = state_q;
    left_d    = left_q;
    right_d   = right_q;
    upd_d     = 1'b0;
    uf_d      = uf_q;
    ticks_d   = ticks_q;
    ticks_nxt = ticks_q + TickW'(1);

    case (state_q)
      StIdle: begin
        if (count_d >= CntW'(PREFILL)) begin
          state_d = StRun;
        end
      end
      StRun, StUnder: begin
        if (clken48kHz) begin
          if (!empty) begin
            left_d  = $signed(head[2*WIDTH-1:WIDTH]);
            right_d = $signed(head[WIDTH-1:0]);
            upd_d   = 1'b1;
            state_d = StRun;
            ticks_d = '0;
          end else begin
            uf_d = (uf_q == 8'hFF) ? uf_q : uf_q + 8'd1;
            // ticks_q is always 0 in StRun, so ticks_nxt starts the run at 1.
            if (ticks_nxt == TickW'(MUTE_AFTER)) begin
              left_d  = '0;
              right_d = '0;
              upd_d   = 1'b1;
              state_d = StIdle;
              ticks_d = '0;
            end else begin
              state_d = StUnder;
              ticks_d = ticks_nxt;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = StIdle;
      left_d   = '0;
      right_d  = '0;
      upd_d    = 1'b0;
      uf_d     = '0;
      ticks_d  = '0;
    end
  end

  // Sample storage carries no reset; the count alone defines valid entries.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      left_q   <= '0;
      right_q  <= '0;
      upd_q    <= 1'b0;
      uf_q     <= '0;
      ticks_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      upd_q    <= upd_d;
      uf_q     <= uf_d;
      ticks_q  <= ticks_d;
    end
  end

  assign LEFTout       = left_q;
  assign RIGHTout      = right_q;
  assign sample_upd    = upd_q;
  assign running       = (state_q != StIdle);
  assign fill_level    = count_q;
  assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Bench for audio_sample_scheduler: vector table for prefill/playout/underrun, a scoreboard
// checking every sample_upd, and hand sequences for full, flush, mute and async reset.
module tb_audio_sample_scheduler;
  localparam int unsigned W = 18;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clken = 1'b0;
  logic flush = 1'b0;
  logic signed [W-1:0] left_o, right_o;
  logic upd, running;
  logic [3:0] fill;
  logic [7:0] uf;

  audio_sample_scheduler_if #(.WIDTH(W)) u_if ();

  audio_sample_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .clken48kHz    (clken),
    .flush         (flush),
    .in_if         (u_if),
    .LEFTout       (left_o),
    .RIGHTout      (right_o),
    .sample_upd    (upd),
    .running       (running),
    .fill_level    (fill),
    .underflow_cnt (uf)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int l; int r; } pair_t;
  pair_t exp_q[$];

  typedef struct {
    logic v; int l; int r; logic ck;
    int e_fill; logic e_run; logic e_ready; int e_l; int e_r; int e_uf; logic e_upd;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every update must be the next queued pair, or a mute (0,0) when none is queued.
  always @(negedge clock) begin
    pair_t e;
    if (reset && upd) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '{0, 0};
      chk("upd_left", int'(left_o), e.l);
      chk("upd_right", int'(right_o), e.r);
    end
  end

  // Drive one cycle of inputs just after a falling edge; returns just after the next one.
  task automatic step(input logic v, input int l, input int r, input logic ck);
    logic acc;
    u_if.in_valid = v;
    u_if.in_left  = l[W-1:0];
    u_if.in_right = r[W-1:0];
    clken         = ck;
    #1 acc = v && u_if.in_ready;
    @(negedge clock);
    if (acc) exp_q.push_back('{l, r});
    u_if.in_valid = 1'b0;
    clken         = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.in_valid = 1'b0;
    u_if.in_left  = '0;
    u_if.in_right = '0;

    vecs[0]  = '{1'b1, 100,  -7, 1'b0, 1, 1'b0, 1'b1,   0,   0, 0, 1'b0};
    vecs[1]  = '{1'b1, 105,   0, 1'b0, 2, 1'b0, 1'b1,   0,   0, 0, 1'b0};
    vecs[2]  = '{1'b1, 110,   7, 1'b0, 3, 1'b0, 1'b1,   0,   0, 0, 1'b0};
    vecs[3]  = '{1'b0,   0,   0, 1'b1, 3, 1'b0, 1'b1,   0,   0, 0, 1'b0};
    vecs[4]  = '{1'b0,   0,   0, 1'b1, 3, 1'b0, 1'b1,   0,   0, 0, 1'b0};
    vecs[5]  = '{1'b1, 115,  14, 1'b0, 4, 1'b1, 1'b1,   0,   0, 0, 1'b0};
    vecs[6]  = '{1'b0,   0,   0, 1'b1, 3, 1'b1, 1'b1, 100,  -7, 0, 1'b1};
    vecs[7]  = '{1'b0,   0,   0, 1'b0, 3, 1'b1, 1'b1, 100,  -7, 0, 1'b0};
    vecs[8]  = '{1'b0,   0,   0, 1'b1, 2, 1'b1, 1'b1, 105,   0, 0, 1'b1};
    vecs[9]  = '{1'b1, 120,  21, 1'b1, 2, 1'b1, 1'b1, 110,   7, 0, 1'b1};
    vecs[10] = '{1'b0,   0,   0, 1'b1, 1, 1'b1, 1'b1, 115,  14, 0, 1'b1};
    vecs[11] = '{1'b0,   0,   0, 1'b1, 0, 1'b1, 1'b1, 120,  21, 0, 1'b1};
    vecs[12] = '{1'b0,   0,   0, 1'b1, 0, 1'b1, 1'b1, 120,  21, 1, 1'b0};
    vecs[13] = '{1'b1, 130, -30, 1'b1, 1, 1'b1, 1'b1, 120,  21, 2, 1'b0};
    vecs[14] = '{1'b0,   0,   0, 1'b1, 0, 1'b1, 1'b1, 130, -30, 2, 1'b1};

    // Reset values
    #2;
    chk("rst left", int'(left_o), 0);
    chk("rst running", int'(running), 0);
    chk("rst fill", int'(fill), 0);
    chk("rst uf", int'(uf), 0);
    chk("rst upd", int'(upd), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;

    // Prefill, ordered playout, same-edge push/pop, underrun and recovery
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].v, vecs[i].l, vecs[i].r, vecs[i].ck);
      #1;
      chk($sformatf("vec%0d fill", i), int'(fill), vecs[i].e_fill);
      chk($sformatf("vec%0d running", i), int'(running), int'(vecs[i].e_run));
      chk($sformatf("vec%0d in_ready", i), int'(u_if.in_ready), int'(vecs[i].e_ready));
      chk($sformatf("vec%0d left", i), int'(left_o), vecs[i].e_l);
      chk($sformatf("vec%0d right", i), int'(right_o), vecs[i].e_r);
      chk($sformatf("vec%0d uf", i), int'(uf), vecs[i].e_uf);
      chk($sformatf("vec%0d upd", i), int'(upd), int'(vecs[i].e_upd));
    end

    // Full FIFO: 9th pair refused, one tick frees exactly one slot
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 200 + k, -k, 1'b0);
      #1;
      if (k == 6) chk("full k6 ready", int'(u_if.in_ready), 1);
      if (k >= 7) begin
        chk($sformatf("full k%0d fill", k), int'(fill), 8);
        chk($sformatf("full k%0d ready", k), int'(u_if.in_ready), 0);
      end
    end
    step(1'b1, 209, -9, 1'b1);
    #1;
    chk("full tick fill", int'(fill), 7);
    chk("full tick ready", int'(u_if.in_ready), 1);
    chk("full tick left", int'(left_o), 200);

    // Flush during RUN with fill 5 and in_valid high
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    #1;
    chk("pre-flush fill", int'(fill), 5);
    u_if.in_valid = 1'b1;
    u_if.in_left  = 18'd500;
    flush = 1'b1;
    #1;
    chk("flush in_ready", int'(u_if.in_ready), 0);
    @(negedge clock);
    exp_q.delete();
    flush = 1'b0;
    u_if.in_valid = 1'b0;
    #1;
    chk("flush fill", int'(fill), 0);
    chk("flush running", int'(running), 0);
    chk("flush left", int'(left_o), 0);
    chk("flush uf", int'(uf), 0);
    chk("flush upd", int'(upd), 0);
    step(1'b0, 0, 0, 1'b1);
    #1;
    chk("idle tick uf", int'(uf), 0);
    chk("idle tick running", int'(running), 0);

    // Starvation: hold three ticks, mute on the fourth
    for (int k = 0; k < 4; k++) step(1'b1, 300 + k, k, 1'b0);
    #1;
    chk("starve running", int'(running), 1);
    for (int k = 0; k < 4; k++) step(1'b0, 0, 0, 1'b1);
    for (int t = 1; t <= 4; t++) begin
      step(1'b0, 0, 0, 1'b1);
      #1;
      chk($sformatf("starve t%0d uf", t), int'(uf), t);
      chk($sformatf("starve t%0d left", t), int'(left_o), (t < 4) ? 303 : 0);
      chk($sformatf("starve t%0d right", t), int'(right_o), (t < 4) ? 3 : 0);
      chk($sformatf("starve t%0d running", t), int'(running), (t < 4) ? 1 : 0);
      chk($sformatf("starve t%0d upd", t), int'(upd), (t < 4) ? 0 : 1);
    end
    step(1'b0, 0, 0, 1'b1);
    #1;
    chk("muted tick uf", int'(uf), 4);
    chk("muted tick upd", int'(upd), 0);

    // Async reset while a fresh sample is on the outputs
    for (int k = 0; k < 4; k++) step(1'b1, 400 + k, -k, 1'b0);
    #1;
    clken = 1'b1;
    @(posedge clock);
    #2;
    chk("pre-reset upd", int'(upd), 1);
    chk("pre-reset left", int'(left_o), 400);
    reset = 1'b0;
    #1;
    chk("areset left", int'(left_o), 0);
    chk("areset right", int'(right_o), 0);
    chk("areset upd", int'(upd), 0);
    chk("areset running", int'(running), 0);
    chk("areset fill", int'(fill), 0);
    chk("areset uf", int'(uf), 0);
    clken = 1'b0;
    @(negedge clock);
    exp_q.delete();
    reset = 1'b1;
    step(1'b0, 0, 0, 1'b1);
    #1;
    chk("post-reset fill", int'(fill), 0);
    chk("post-reset upd", int'(upd), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
